// File: rtl/elastic_pipe_chain.sv
// Elastic valid/ready register chain. Words pack toward the output and empty stages are filled.
// Each stage can be flushed. A global stall freezes the chain. The registered occupancy count holds the number of valid stages.
module elastic_pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             load,
  input  logic             flush,
  input  logic             prevValid,
  input  logic [WIDTH-1:0] prevData,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             validNext
);
  // Flush is applied after the move, so a word arriving in this cycle is discarded too.
  always_comb validNext = (load ? prevValid : valid) & ~flush;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= validNext;
      // A bubble leaves stale data in place. That data is never seen, because valid is 0.
      if (load && prevValid) data <= prevData;
    end
  end
endmodule

module elastic_pipe_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = $clog2(STAGES+1)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              InValid,
  output logic              InReady,
  input  logic [WIDTH-1:0]  InData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [WIDTH-1:0]  OutData,
  input  logic              Stall,
  input  logic [STAGES-1:0] Flush,
  output logic [CNT_W-1:0]  Occupancy,
  output logic [STAGES-1:0] StageValid
);
  logic [STAGES:0]            rdy;
  logic [STAGES:0]            vldPipe;
  logic [STAGES:0][WIDTH-1:0] datPipe;
  logic [STAGES-1:0]          validNext;
  logic [CNT_W-1:0]           occNext;
  logic [CNT_W-1:0]           occ;

  assign vldPipe[0] = InValid;
  assign datPipe[0] = InData;
  assign rdy[STAGES] = OutReady & ~Stall;

  for (genvar i = 0; i < STAGES; i++) begin : gStage
    // A stage accepts a word when it is empty or when its own word moves on in the same cycle.
    assign rdy[i] = ~Stall & (~vldPipe[i+1] | rdy[i+1]);

    elastic_pipe_stage #(.WIDTH(WIDTH)) uStage (
      .Clk       (Clk),
      .Rst       (Rst),
      .load      (rdy[i]),
      .flush     (Flush[i]),
      .prevValid (vldPipe[i]),
      .prevData  (datPipe[i]),
      .valid     (vldPipe[i+1]),
      .data      (datPipe[i+1]),
      .validNext (validNext[i])
    );
  end

  always_comb begin
    occNext = '0;
    for (int i = 0; i < STAGES; i++) occNext = occNext + CNT_W'(validNext[i]);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) occ <= '0;
    else      occ <= occNext;
  end

  // InReady is gated with Rst, so it stays low while reset is held.
  assign InReady    = rdy[0] & Rst;
  assign OutValid   = vldPipe[STAGES];
  assign OutData    = datPipe[STAGES];
  assign StageValid = vldPipe[STAGES:1];
  assign Occupancy  = occ;
endmodule
